// File: rtl/partition_alloc_arbiter_pkg.sv
// thiele_palloc_pkg: FSM states, reset constants and popcount shared by partition_alloc_arbiter
package thiele_palloc_pkg;
  typedef enum logic [2:0] {IDLE, GRANT, SEARCH, ALLOC, RESP} state_e;
  localparam int MAX_MASK_W = 64;
  localparam logic [MAX_MASK_W-1:0] RST_MASK = 1;
  localparam logic [31:0] RST_ID = 0;
  localparam logic [63:0] RST_MU = 1;
  function automatic logic [6:0] popcount(input logic [MAX_MASK_W-1:0] v);
    popcount = '0;
    for (int i = 0; i < MAX_MASK_W; i++) popcount = popcount + 7'(v[i]);
  endfunction
endpackage

// File: rtl/partition_alloc_arbiter_if.sv
// partition_alloc_arbiter_if: requester request/response bundle; requesters are master, arbiter is slave
interface partition_alloc_arbiter_if #(parameter int NREQ = 4, parameter int MASK_W = 64, parameter int ID_W = 32);
  logic [NREQ-1:0] req_valid, req_ready, rsp_valid;
  logic [NREQ*MASK_W-1:0] req_mask;
  logic [ID_W-1:0] rsp_id;
  logic rsp_new, rsp_err;
  modport master(output req_valid, req_mask, input req_ready, rsp_valid, rsp_id, rsp_new, rsp_err);
  modport slave(input req_valid, req_mask, output req_ready, rsp_valid, rsp_id, rsp_new, rsp_err);
endinterface

// File: rtl/partition_alloc_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first requester at or after ptr wins
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);
  logic [IW:0] j;
  always_comb begin
    idx = '0;
    j = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (IW+1)'(ptr) + (IW+1)'(k);
      j = j >= (IW+1)'(NREQ) ? j - (IW+1)'(NREQ) : j;
      if (req[IW'(j)]) idx = IW'(j);
    end
  end
  assign gnt = |req ? NREQ'(1) << idx : '0;
endmodule

// File: rtl/partition_alloc_arbiter.sv
// partition_alloc_arbiter: round-robin shared PNEW allocator with dedup search and mu charging
// PALLOC_DEDUP_EN enables the sequential dedup search; otherwise every nonzero mask allocates.
module partition_alloc_arbiter
  import thiele_palloc_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int NSLOTS = 64,
  parameter int MASK_W = 64,
  parameter int ID_W   = 32,
  parameter int MU_W   = 64,
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1,
  localparam int SW = $clog2(NSLOTS),
  localparam int NW = SW + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  partition_alloc_arbiter_if.slave bus,
  output logic [MU_W-1:0] mu_discovery,
  output logic [NW-1:0]   num_modules,
  output logic            busy
);
`ifdef PALLOC_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif
  state_e state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, g_q, g_d, pick;
  logic [NREQ-1:0] gnt, req_ready, rsp_valid;
  logic [MASK_W-1:0] mask_q, mask_d;
  logic [SW-1:0] idx_q, idx_d;
  logic [NW-1:0] num_q, num_d;
  logic [ID_W-1:0] next_id_q, next_id_d, rsp_id_q, rsp_id_d;
  logic [MU_W-1:0] mu_q, mu_d;
  logic [MU_W+7:0] mu_sum;
  logic rsp_new_q, rsp_new_d, rsp_err_q, rsp_err_d, we;
  logic [MASK_W-1:0] mask_mem [NSLOTS];
  logic [ID_W-1:0] id_mem [NSLOTS];
  rr_arbiter #(.NREQ(NREQ)) u_arb (.req(bus.req_valid), .ptr(ptr_q), .gnt(gnt), .idx(pick));
  assign mu_sum = (MU_W+8)'(mu_q) + (MU_W+8)'(popcount(MAX_MASK_W'(mask_q)));
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    g_d = g_q;
    mask_d = mask_q;
    idx_d = idx_q;
    num_d = num_q;
    next_id_d = next_id_q;
    mu_d = mu_q;
    rsp_id_d = rsp_id_q;
    rsp_new_d = rsp_new_q;
    rsp_err_d = rsp_err_q;
    we = 1'b0;
    req_ready = '0;
    rsp_valid = '0;
    case (state_q)
      IDLE: begin
        g_d = |gnt ? pick : g_q;
        state_d = |gnt ? GRANT : IDLE;
      end
      GRANT: begin
        req_ready = NREQ'(1) << g_q;
        ptr_d = g_q == IW'(NREQ - 1) ? '0 : g_q + IW'(1);
        mask_d = bus.req_mask[g_q*MASK_W +: MASK_W];
        idx_d = '0;
        state_d = !bus.req_valid[g_q] ? IDLE : (mask_d == '0 || !DEDUP) ? ALLOC : SEARCH;
      end
      SEARCH: begin
        if (mask_mem[idx_q] == mask_q) begin
          rsp_id_d = id_mem[idx_q];
          rsp_new_d = 1'b0;
          rsp_err_d = 1'b0;
          state_d = RESP;
        end else begin
          idx_d = idx_q + SW'(1);
          state_d = NW'(idx_q) + NW'(1) == num_q ? ALLOC : SEARCH;
        end
      end
      ALLOC: begin
        rsp_err_d = mask_q == '0 || num_q == NW'(NSLOTS);
        rsp_new_d = !rsp_err_d;
        rsp_id_d = rsp_err_d ? '1 : next_id_q;
        we = !rsp_err_d;
        next_id_d = we ? next_id_q + ID_W'(1) : next_id_q;
        num_d = we ? num_q + NW'(1) : num_q;
        mu_d = !we ? mu_q : |mu_sum[MU_W+7:MU_W] ? '1 : mu_sum[MU_W-1:0];
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = NREQ'(1) << g_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      g_q <= '0;
      mask_q <= '0;
      idx_q <= '0;
      num_q <= NW'(1);
      next_id_q <= ID_W'(1);
      mu_q <= MU_W'(RST_MU);
      rsp_id_q <= '0;
      rsp_new_q <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      g_q <= g_d;
      mask_q <= mask_d;
      idx_q <= idx_d;
      num_q <= num_d;
      next_id_q <= next_id_d;
      mu_q <= mu_d;
      rsp_id_q <= rsp_id_d;
      rsp_new_q <= rsp_new_d;
      rsp_err_q <= rsp_err_d;
    end
  end
  // Only slot 0 needs reinitialising: slots at or beyond num_modules are never read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_mem[0] <= MASK_W'(RST_MASK);
      id_mem[0] <= ID_W'(RST_ID);
    end else if (we) begin
      mask_mem[num_q[SW-1:0]] <= mask_q;
      id_mem[num_q[SW-1:0]] <= next_id_q;
    end
  end
  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_id = rsp_id_q;
  assign bus.rsp_new = rsp_new_q;
  assign bus.rsp_err = rsp_err_q;
  assign mu_discovery = mu_q;
  assign num_modules = num_q;
  assign busy = state_q != IDLE;
endmodule
